// File: rtl/car_detection_overlay_pkg.sv
// Shared types and defaults for the car-detection box overlay.
// RGB packs as {r,g,b}; box buses pack as {xs,ys,xe,ye}.
package car_detection_overlay_pkg;

  localparam int DEF_COORD_W = 16;
  localparam int RGB_W       = 24;
  localparam int CNT_W       = 5;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t pack_rgb(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return '{r: r, g: g, b: b};
  endfunction

endpackage

// File: rtl/car_detection_overlay_if.sv
// Video in/out, detector bbox stream and overlay controls.
// master drives video/boxes, slave is the overlay block.
interface car_detection_overlay_if
  import car_detection_overlay_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W
);
  logic               de;
  logic               hsync;
  logic               vsync;
  logic [7:0]         r;
  logic [7:0]         g;
  logic [7:0]         b;
  logic               bbox_valid;
  logic [COORD_W-1:0] bbox_x_start;
  logic [COORD_W-1:0] bbox_y_start;
  logic [COORD_W-1:0] bbox_x_end;
  logic [COORD_W-1:0] bbox_y_end;
  logic               overlay_en;
  logic [RGB_W-1:0]   box_rgb;
  logic               de_out;
  logic               hsync_out;
  logic               vsync_out;
  logic [7:0]         r_out;
  logic [7:0]         g_out;
  logic [7:0]         b_out;
  logic [CNT_W-1:0]   box_count;
  logic               overflow;

  modport master (
    output de, hsync, vsync, r, g, b,
    output bbox_valid, bbox_x_start, bbox_y_start,
    output bbox_x_end, bbox_y_end,
    output overlay_en, box_rgb,
    input  de_out, hsync_out, vsync_out,
    input  r_out, g_out, b_out,
    input  box_count, overflow
  );

  modport slave (
    input  de, hsync, vsync, r, g, b,
    input  bbox_valid, bbox_x_start, bbox_y_start,
    input  bbox_x_end, bbox_y_end,
    input  overlay_en, box_rgb,
    output de_out, hsync_out, vsync_out,
    output r_out, g_out, b_out,
    output box_count, overflow
  );
endinterface

// File: rtl/car_detection_overlay_border_hit.sv
// Combinational test: is pixel (x,y) on the border band of one box.
// Sums are one bit wider than coordinates so they never wrap.
module bbox_border_hit #(
  parameter int COORD_W = 16,
  parameter int LINE_W  = 2
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_xs,
  input  logic [COORD_W-1:0] i_ys,
  input  logic [COORD_W-1:0] i_xe,
  input  logic [COORD_W-1:0] i_ye,
  output logic               o_border
);
  localparam logic [COORD_W:0] LW = (COORD_W+1)'(LINE_W);

  logic [COORD_W:0] w_x, w_y, w_xs, w_ys, w_xe, w_ye;
  logic             w_inside, w_edge;

  assign w_x  = {1'b0, i_x};
  assign w_y  = {1'b0, i_y};
  assign w_xs = {1'b0, i_xs};
  assign w_ys = {1'b0, i_ys};
  assign w_xe = {1'b0, i_xe};
  assign w_ye = {1'b0, i_ye};

  assign w_inside = (w_xs <= w_x) && (w_x <= w_xe) &&
                    (w_ys <= w_y) && (w_y <= w_ye);

  assign w_edge = (w_x < w_xs + LW) || (w_x + LW > w_xe) ||
                  (w_y < w_ys + LW) || (w_y + LW > w_ye);

  assign o_border = w_inside && w_edge;
endmodule

// File: rtl/car_detection_overlay.sv
// Captures detector boxes per frame and draws them as borders
// on the next frame's video, two-cycle pipelined.
module car_detection_overlay
  import car_detection_overlay_pkg::*;
#(
  parameter int MAX_BOXES   = 8,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int LINE_W      = 2,
  parameter int IMAGE_WIDTH = 64
) (
  input logic clk,
  input logic reset,
  car_detection_overlay_if.slave bus
);
  localparam logic [COORD_W-1:0] XMAX = COORD_W'(IMAGE_WIDTH - 1);
  localparam logic [CNT_W-1:0]   MAXB = CNT_W'(MAX_BOXES);

  typedef struct packed {
    logic [COORD_W-1:0] xs;
    logic [COORD_W-1:0] ys;
    logic [COORD_W-1:0] xe;
    logic [COORD_W-1:0] ye;
  } box_t;

  logic [COORD_W-1:0]   r_x, r_y;
  logic                 r_de_prev, r_vs_prev;
  box_t                 r_wr_box [MAX_BOXES];
  box_t                 r_rd_box [MAX_BOXES];
  logic [MAX_BOXES-1:0] r_rd_vld;
  logic [CNT_W-1:0]     r_wr_cnt, r_box_count;
  logic                 r_wr_ovf, r_ovf;

  logic                 r_de1, r_hs1, r_vs1, r_en1;
  rgb_t                 r_pix1;
  logic [MAX_BOXES-1:0] r_border1;
  logic                 r_de2, r_hs2, r_vs2;
  rgb_t                 r_pix2;

  logic                 w_vs_rise, w_de_fall;
  logic                 w_box_ok, w_full, w_we;
  logic [CNT_W-1:0]     w_wr_idx;
  box_t                 w_box;
  logic [MAX_BOXES-1:0] w_border;

  assign w_vs_rise = bus.vsync & ~r_vs_prev;
  assign w_de_fall = ~bus.de & r_de_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_de_prev <= 1'b0;
      r_vs_prev <= 1'b0;
    end else begin
      r_de_prev <= bus.de;
      r_vs_prev <= bus.vsync;
      if (w_vs_rise) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_de_fall) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else if (bus.de && r_x != XMAX) begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign w_box = '{xs: bus.bbox_x_start, ys: bus.bbox_y_start,
                   xe: bus.bbox_x_end,   ye: bus.bbox_y_end};

  // A box arriving with the vsync edge lands in the fresh bank.
  assign w_box_ok = bus.bbox_valid &&
                    (w_box.xs <= w_box.xe) && (w_box.ys <= w_box.ye);
  assign w_wr_idx = w_vs_rise ? '0 : r_wr_cnt;
  assign w_full   = w_wr_idx >= MAXB;
  assign w_we     = w_box_ok && !w_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_BOXES; i++) begin
        r_wr_box[i] <= '0;
        r_rd_box[i] <= '0;
      end
      r_rd_vld    <= '0;
      r_wr_cnt    <= '0;
      r_wr_ovf    <= 1'b0;
      r_box_count <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_vs_rise) begin
        r_rd_box    <= r_wr_box;
        r_box_count <= r_wr_cnt;
        r_ovf       <= r_wr_ovf;
        for (int i = 0; i < MAX_BOXES; i++)
          r_rd_vld[i] <= CNT_W'(i) < r_wr_cnt;
      end
      for (int i = 0; i < MAX_BOXES; i++)
        if (w_we && w_wr_idx == CNT_W'(i))
          r_wr_box[i] <= w_box;
      if (w_we)
        r_wr_cnt <= w_wr_idx + 1'b1;
      else if (w_vs_rise)
        r_wr_cnt <= '0;
      r_wr_ovf <= (w_vs_rise ? 1'b0 : r_wr_ovf) | (w_box_ok & w_full);
    end
  end

  for (genvar g = 0; g < MAX_BOXES; g++) begin : g_hit
    bbox_border_hit #(
      .COORD_W(COORD_W),
      .LINE_W (LINE_W)
    ) u_hit (
      .i_x     (r_x),
      .i_y     (r_y),
      .i_xs    (r_rd_box[g].xs),
      .i_ys    (r_rd_box[g].ys),
      .i_xe    (r_rd_box[g].xe),
      .i_ye    (r_rd_box[g].ye),
      .o_border(w_border[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_de1     <= 1'b0;
      r_hs1     <= 1'b0;
      r_vs1     <= 1'b0;
      r_en1     <= 1'b0;
      r_pix1    <= '0;
      r_border1 <= '0;
      r_de2     <= 1'b0;
      r_hs2     <= 1'b0;
      r_vs2     <= 1'b0;
      r_pix2    <= '0;
    end else begin
      r_de1     <= bus.de;
      r_hs1     <= bus.hsync;
      r_vs1     <= bus.vsync;
      r_en1     <= bus.overlay_en;
      r_pix1    <= pack_rgb(bus.r, bus.g, bus.b);
      r_border1 <= w_border & r_rd_vld;
      r_de2     <= r_de1;
      r_hs2     <= r_hs1;
      r_vs2     <= r_vs1;
      r_pix2    <= (r_en1 && |r_border1 && r_de1) ?
                   rgb_t'(bus.box_rgb) : r_pix1;
    end
  end

  assign bus.de_out    = r_de2;
  assign bus.hsync_out = r_hs2;
  assign bus.vsync_out = r_vs2;
  assign bus.r_out     = r_pix2.r;
  assign bus.g_out     = r_pix2.g;
  assign bus.b_out     = r_pix2.b;
  assign bus.box_count = r_box_count;
  assign bus.overflow  = r_ovf;
endmodule
